decode_stage_pipelined: RTL

//  LEGv8 decode stage with an integrated register file and an ID/EX pipeline register.

---
 rtl/decode_stage_pipelined_if.sv | 48 ++++
 rtl/decode_stage_pipelined.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipelined_if.sv
// Handshake and datapath bundle between IF/ID, writeback and the decode stage's ID/EX register.
// master = upstream/environment side, slave = decode stage.
interface decode_stage_pipelined_if #(
    parameter int unsigned WORD      = 64,
    parameter int unsigned INSTR_LEN = 32,
    parameter int unsigned RA_W      = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_LEN-1:0] instruction;
    logic                 flush;

    logic                 wb_en;
    logic [RA_W-1:0]      wb_addr;
    logic [WORD-1:0]      wb_data;

    logic                 out_valid;
    logic                 out_ready;
    logic                 reg2_loc;
    logic                 uncondbranch;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 alu_src;
    logic                 reg_write;
    logic [1:0]           alu_op;
    logic [WORD-1:0]      read_data1;
    logic [WORD-1:0]      read_data2;
    logic [WORD-1:0]      sign_extended_output;
    logic [10:0]          opcode;
    logic [RA_W-1:0]      rd;
    logic                 illegal;

    modport master (
        output in_valid, instruction, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
               mem_write, alu_src, reg_write, alu_op, read_data1, read_data2,
               sign_extended_output, opcode, rd, illegal
    );

    modport slave (
        input  in_valid, instruction, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
               mem_write, alu_src, reg_write, alu_op, read_data1, read_data2,
               sign_extended_output, opcode, rd, illegal
    );
endinterface

// File: rtl/decode_stage_pipelined.sv
// LEGv8 decode stage: main control, immediate extension, register file and ID/EX register.
// Optional DECODE_WB_BYPASS_EN makes same-cycle writebacks visible to register reads.
module decode_stage_pipelined #(
    parameter int unsigned WORD      = 64,
    parameter int unsigned INSTR_LEN = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned RA_W      = 5
) (
    input logic                     clk,
    input logic                     reset,
    decode_stage_pipelined_if.slave bus
);
    localparam logic [RA_W-1:0] XZR     = RA_W'(NUM_REGS - 1);
    localparam logic [10:0]     OP_ADD  = 11'b10001011000;
    localparam logic [10:0]     OP_SUB  = 11'b11001011000;
    localparam logic [10:0]     OP_AND  = 11'b10001010000;
    localparam logic [10:0]     OP_ORR  = 11'b10101010000;
    localparam logic [10:0]     OP_LDUR = 11'b11111000010;
    localparam logic [10:0]     OP_STUR = 11'b11111000000;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RTYPE,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B
    } instr_class_e;

    logic [INSTR_LEN-1:0] instr;
    logic [10:0]          op;
    instr_class_e         cls;

    logic            c_reg2_loc, c_uncondbranch, c_branch, c_mem_read;
    logic            c_mem_to_reg, c_mem_write, c_alu_src, c_reg_write, c_illegal;
    logic [1:0]      c_alu_op;
    logic [WORD-1:0] c_imm;

    logic [RA_W-1:0] rn_addr, r2_addr;
    logic [WORD-1:0] rn_data, r2_data;
    logic [WORD-1:0] regs [NUM_REGS];
    logic            capture;

    assign instr        = bus.instruction;
    assign op           = instr[31:21];
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        cls = CLS_ILLEGAL;
        casez (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CLS_RTYPE;
            OP_LDUR:                        cls = CLS_LDUR;
            OP_STUR:                        cls = CLS_STUR;
            11'b10110100???:                cls = CLS_CBZ;
            11'b000101?????:                cls = CLS_B;
            default:                        cls = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        c_reg2_loc     = 1'b0;
        c_uncondbranch = 1'b0;
        c_branch       = 1'b0;
        c_mem_read     = 1'b0;
        c_mem_to_reg   = 1'b0;
        c_mem_write    = 1'b0;
        c_alu_src      = 1'b0;
        c_reg_write    = 1'b0;
        c_alu_op       = 2'b00;
        c_illegal      = 1'b0;
        c_imm          = '0;
        case (cls)
            CLS_RTYPE: begin
                c_reg_write = 1'b1;
                c_alu_op    = 2'b10;
            end
            CLS_LDUR: begin
                c_alu_src    = 1'b1;
                c_mem_to_reg = 1'b1;
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
                c_imm        = WORD'($signed(instr[20:12]));
            end
            CLS_STUR: begin
                c_reg2_loc  = 1'b1;
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
                c_imm       = WORD'($signed(instr[20:12]));
            end
            CLS_CBZ: begin
                c_reg2_loc = 1'b1;
                c_branch   = 1'b1;
                c_alu_op   = 2'b01;
                c_imm      = WORD'($signed(instr[23:5]));
            end
            CLS_B: begin
                c_uncondbranch = 1'b1;
                c_imm          = WORD'($signed(instr[25:0]));
            end
            default: c_illegal = 1'b1;
        endcase
    end

    assign rn_addr = instr[9:5];
    assign r2_addr = c_reg2_loc ? instr[4:0] : instr[20:16];

    always_comb begin
        rn_data = (rn_addr == XZR) ? '0 : regs[rn_addr];
        r2_data = (r2_addr == XZR) ? '0 : regs[r2_addr];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr == rn_addr && rn_addr != XZR) rn_data = bus.wb_data;
        if (bus.wb_en && bus.wb_addr == r2_addr && r2_addr != XZR) r2_data = bus.wb_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != XZR) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Operands are snapshotted at capture only, so a stalled entry never sees later writebacks.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid            <= 1'b0;
            bus.reg2_loc             <= 1'b0;
            bus.uncondbranch         <= 1'b0;
            bus.branch               <= 1'b0;
            bus.mem_read             <= 1'b0;
            bus.mem_to_reg           <= 1'b0;
            bus.mem_write            <= 1'b0;
            bus.alu_src              <= 1'b0;
            bus.reg_write            <= 1'b0;
            bus.alu_op               <= '0;
            bus.read_data1           <= '0;
            bus.read_data2           <= '0;
            bus.sign_extended_output <= '0;
            bus.opcode               <= '0;
            bus.rd                   <= '0;
            bus.illegal              <= 1'b0;
        end else begin
            if (bus.flush)          bus.out_valid <= 1'b0;
            else if (capture)       bus.out_valid <= 1'b1;
            else if (bus.out_ready) bus.out_valid <= 1'b0;

            if (capture) begin
                bus.reg2_loc             <= c_reg2_loc;
                bus.uncondbranch         <= c_uncondbranch;
                bus.branch               <= c_branch;
                bus.mem_read             <= c_mem_read;
                bus.mem_to_reg           <= c_mem_to_reg;
                bus.mem_write            <= c_mem_write;
                bus.alu_src              <= c_alu_src;
                bus.reg_write            <= c_reg_write;
                bus.alu_op               <= c_alu_op;
                bus.read_data1           <= rn_data;
                bus.read_data2           <= r2_data;
                bus.sign_extended_output <= c_imm;
                bus.opcode               <= op;
                bus.rd                   <= instr[4:0];
                bus.illegal              <= c_illegal;
            end
        end
    end
endmodule
